// File: rtl/imem_loader_pkg.sv
// Shared constants and state type for the R500 run-time program loader.
package r500_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        RESP
    } ldr_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, IMEM write port, core reset and response channel of the loader.
interface imem_loader_if #(parameter int ADDR_WIDTH = 10);

    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_rst_n;
    logic [7:0]            resp_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  load_done;
    logic                  load_err;

    modport slave (
        input  rx_data, rx_valid, resp_ready,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n,
               resp_data, resp_valid, load_done, load_err
    );

    modport master (
        output rx_data, rx_valid, resp_ready,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n,
               resp_data, resp_valid, load_done, load_err
    );

endinterface

// File: rtl/imem_loader_timeout.sv
// Inter-byte idle timer: down-counter reloaded on every accepted byte or while out of frame.
module ldr_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle; the FSM leaves the frame at once.
    assign expired_o = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: packs LE words into IMEM, verifies checksum, gates core reset.
//   state | meaning
//   IDLE  | drop bytes until SYNC
//   LEN0  | expect word count low byte
//   LEN1  | expect word count high byte, range-check
//   DATA  | pack 4 bytes per word, write IMEM
//   CSUM  | expect checksum byte
//   RESP  | present ACK/NAK until consumed
module imem_loader
    import r500_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter bit BOOT_RUN       = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_loader_if.slave   bus
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    ldr_state_t            state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [15:0]           len_q, len_d;
    logic [16:0]           word_cnt_q, word_cnt_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           pack_q, pack_d;
    logic [7:0]            csum_q, csum_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;
    logic [7:0]            resp_data_q, resp_data_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;

    logic                  rx_ready;
    logic                  accept;
    logic                  in_frame;
    logic                  expired;
    logic [15:0]           len_rx;
    logic [7:0]            csum_next;

    assign rx_ready  = (state_q != RESP);
    assign accept    = bus.rx_valid && rx_ready;
    assign in_frame  = (state_q == LEN0) || (state_q == LEN1) ||
                       (state_q == DATA) || (state_q == CSUM);
    assign len_rx    = {bus.rx_data, len_lo_q};
    assign csum_next = csum_q + bus.rx_data;

    ldr_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (accept),
        .en_i      (in_frame),
        .expired_o (expired)
    );

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        byte_idx_d   = byte_idx_q;
        pack_d       = pack_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_rst_n_d  = cpu_rst_n_q;
        resp_data_d  = resp_data_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;

        case (state_q)
            IDLE: begin
                if (accept && bus.rx_data == SYNC_BYTE) begin
                    state_d     = LEN0;
                    cpu_rst_n_d = 1'b0;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                    word_cnt_d  = '0;
                    byte_idx_d  = '0;
                    csum_d      = '0;
                end
            end
            LEN0: begin
                if (accept) begin
                    len_lo_d = bus.rx_data;
                    state_d  = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    len_d = len_rx;
                    if (len_rx == '0) begin
                        state_d = CSUM;
                    end else if ({1'b0, len_rx} > MAX_WORDS) begin
                        state_d     = RESP;
                        resp_data_d = NAK_BYTE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    csum_d     = csum_next;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
                        imem_wdata_d = {bus.rx_data, pack_q};
                        word_cnt_d   = word_cnt_q + 17'd1;
                        if (word_cnt_q + 17'd1 == {1'b0, len_q}) begin
                            state_d = CSUM;
                        end
                    end else begin
                        // Shift right so bytes 0..2 end up LSB-first in pack_q.
                        pack_d = {bus.rx_data, pack_q[23:8]};
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    state_d     = RESP;
                    resp_data_d = (csum_next == 8'd0) ? ACK_BYTE : NAK_BYTE;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                    if (resp_data_q == ACK_BYTE) begin
                        load_done_d = 1'b1;
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (expired) begin
            state_d    = IDLE;
            load_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_idx_q   <= '0;
            pack_q       <= '0;
            csum_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_n_q  <= BOOT_RUN;
            resp_data_q  <= '0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_idx_q   <= byte_idx_d;
            pack_q       <= pack_d;
            csum_q       <= csum_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            resp_data_q  <= resp_data_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign bus.rx_ready   = rx_ready;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_rst_n  = cpu_rst_n_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.load_done  = load_done_q;
    assign bus.load_err   = load_err_q;

endmodule
